// File: rtl/tcm_pkg.sv
// Shared types and defaults for the tightly-coupled memory responder.
package tcm_pkg;

    typedef logic [31:0] tcm_word_t;
    typedef logic [3:0]  tcm_be_t;

    localparam int unsigned TCM_DEPTH_LOG2 = 12;
    localparam logic [31:0] TCM_BASE_ADDR  = 32'h0000_0000;

    typedef enum logic {
        CLEAR,
        READY
    } tcm_state_t;

endpackage

// File: rtl/tcm_ram.sv
// True dual-port read-first RAM: port A read-only, port B read/write with byte enables.
module tcm_ram
    import tcm_pkg::*;
#(
    parameter int unsigned ADDR_W = TCM_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [31:0]       a_dout,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_we,
    input  logic [31:0]       b_din,
    output logic [31:0]       b_dout
);

    tcm_word_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
        end
    end

    // Non-blocking update gives read-first behaviour on both ports.
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_dout <= mem[b_addr];
            for (int unsigned i = 0; i < 4; i++) begin
                if (b_we[i]) begin
                    mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/tcm_responder.sv
// TCM responder: instruction/data ports over a dual-port RAM with range checking.
// Optional power-on clear sweep enabled by defining TCM_CLEAR_EN.
module tcm_responder
    import tcm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = TCM_DEPTH_LOG2,
    parameter logic [31:0] BASE_ADDR  = TCM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_ena,
    output logic [31:0] imem_dout,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_din,
    input  logic        dmem_ena,
    input  logic [3:0]  dmem_wen,
    output logic [31:0] dmem_dout,
    output logic        dmem_err,
    output logic        init_busy
);

    localparam int unsigned HI = DEPTH_LOG2 + 2;

    logic [31:0]           i_off, d_off;
    logic                  i_in_range, d_in_range;
    logic [DEPTH_LOG2-1:0] i_idx, d_idx;
    logic                  unused_addr_bits;

    assign i_off      = imem_addr - BASE_ADDR;
    assign d_off      = dmem_addr - BASE_ADDR;
    assign i_in_range = (i_off >> HI) == 32'd0;
    assign d_in_range = (d_off >> HI) == 32'd0;
    assign i_idx      = i_off[HI-1:2];
    assign d_idx      = d_off[HI-1:2];
    assign unused_addr_bits = ^{i_off[1:0], d_off[1:0]};

    logic                  ready;
    logic                  sweep_we;
    logic [DEPTH_LOG2-1:0] sweep_idx;

`ifdef TCM_CLEAR_EN
    tcm_state_t            state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        case (state_q)
            CLEAR: begin
                sweep_we = 1'b1;
                if (cnt_q == '1) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: ;
            default: state_d = CLEAR;
        endcase
    end

    assign ready     = (state_q == READY);
    assign init_busy = (state_q == CLEAR);
    assign sweep_idx = cnt_q;
`else
    assign ready     = 1'b1;
    assign init_busy = 1'b0;
    assign sweep_we  = 1'b0;
    assign sweep_idx = '0;
`endif

    logic                  a_en, b_en;
    logic [DEPTH_LOG2-1:0] b_addr;
    logic [3:0]            b_we;
    logic [31:0]           b_din;
    logic [31:0]           a_dout, b_dout;

    assign a_en   = ready & imem_ena & i_in_range;
    assign b_en   = sweep_we | (ready & dmem_ena & d_in_range);
    assign b_addr = sweep_we ? sweep_idx : d_idx;
    assign b_we   = sweep_we ? 4'hF : dmem_wen;
    assign b_din  = sweep_we ? '0 : dmem_din;

    tcm_ram #(
        .ADDR_W(DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .a_en   (a_en),
        .a_addr (i_idx),
        .a_dout (a_dout),
        .b_en   (b_en),
        .b_addr (b_addr),
        .b_we   (b_we),
        .b_din  (b_din),
        .b_dout (b_dout)
    );

    // RAM output registers have no reset; a registered zero flag masks them
    // after reset, during the sweep and after out-of-range accesses.
    logic i_zero_q, d_zero_q;

    always_ff @(posedge clk) begin
        if (reset || !ready) begin
            i_zero_q <= 1'b1;
            d_zero_q <= 1'b1;
            dmem_err <= 1'b0;
        end else begin
            if (imem_ena) begin
                i_zero_q <= ~i_in_range;
            end
            if (dmem_ena) begin
                d_zero_q <= ~d_in_range;
            end
            dmem_err <= dmem_ena & ~d_in_range;
        end
    end

    assign imem_dout = i_zero_q ? '0 : a_dout;
    assign dmem_dout = d_zero_q ? '0 : b_dout;

endmodule

// File: tb/tb_tcm_responder.sv
// Randomized self-checking bench for tcm_responder (DEPTH_LOG2=4, base 0).
module tb_tcm_responder;

    localparam int unsigned DL2   = 4;
    localparam int unsigned WORDS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, dmem_addr, dmem_din;
    logic        imem_ena, dmem_ena;
    logic [3:0]  dmem_wen;
    logic [31:0] imem_dout, dmem_dout;
    logic        dmem_err, init_busy;

    tcm_responder #(
        .DEPTH_LOG2 (DL2),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_ena  (imem_ena),
        .imem_dout (imem_dout),
        .dmem_addr (dmem_addr),
        .dmem_din  (dmem_din),
        .dmem_ena  (dmem_ena),
        .dmem_wen  (dmem_wen),
        .dmem_dout (dmem_dout),
        .dmem_err  (dmem_err),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [WORDS];
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 4 * WORDS;
    endfunction

    task automatic idle_inputs();
        imem_ena  = 1'b0;
        dmem_ena  = 1'b0;
        dmem_wen  = 4'h0;
        imem_addr = '0;
        dmem_addr = '0;
        dmem_din  = '0;
    endtask

    // One access cycle: predict from the word-array model, clock, compare.
    task automatic cycle(input logic ie, input logic [31:0] ia, input logic de,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        logic       exp_err;
        logic [3:0] wi;
        imem_ena = ie; imem_addr = ia;
        dmem_ena = de; dmem_wen = dw; dmem_addr = da; dmem_din = dd;
        if (ie) begin
            wi    = ia[5:2];
            exp_i = in_range(ia) ? mem_m[wi] : 32'h0;
        end
        exp_err = de && !in_range(da);
        if (de) begin
            if (in_range(da)) begin
                wi    = da[5:2];
                exp_d = mem_m[wi];
                for (int b = 0; b < 4; b++)
                    if (dw[b]) mem_m[wi][8*b +: 8] = dd[8*b +: 8];
            end else begin
                exp_d = 32'h0;
            end
        end
        step();
        check("imem_dout", imem_dout, exp_i);
        check("dmem_dout", dmem_dout, exp_d);
        check("dmem_err", {31'b0, dmem_err}, {31'b0, exp_err});
    endtask

`ifdef TCM_CLEAR_EN
    task automatic measure_sweep(input string tag);
        int n = 0;
        while (init_busy && n < 100) begin
            imem_ena = 1'b1; imem_addr = 32'h0;
            dmem_ena = 1'b1; dmem_wen = 4'hF;
            dmem_addr = (n % 2 == 0) ? 32'h0 : 32'h80;
            dmem_din  = $urandom | 32'h1;
            step();
            n++;
            check({tag, "_imem0"}, imem_dout, 32'h0);
            check({tag, "_dmem0"}, dmem_dout, 32'h0);
            check({tag, "_err0"}, {31'b0, dmem_err}, 32'h0);
        end
        check({tag, "_len"}, n, WORDS);
        idle_inputs();
        for (int k = 0; k < WORDS; k++) mem_m[k] = '0;
        exp_i = '0;
        exp_d = '0;
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        check("rst_imem", imem_dout, 32'h0);
        check("rst_dmem", dmem_dout, 32'h0);
        check("rst_err", {31'b0, dmem_err}, 32'h0);
`ifdef TCM_CLEAR_EN
        check("rst_busy", {31'b0, init_busy}, 32'h1);
        reset = 1'b0;
        measure_sweep("sweep1");
        for (int k = 0; k < WORDS; k++) cycle(1'b1, k * 4, 1'b1, 4'h0, k * 4, 32'h0);

        reset = 1'b1; step(); reset = 1'b0;
        repeat (7) step();
        check("mid_sweep_busy", {31'b0, init_busy}, 32'h1);
        reset = 1'b1; step(); reset = 1'b0;
        measure_sweep("sweep2");
`else
        check("rst_busy", {31'b0, init_busy}, 32'h0);
        reset = 1'b0;
`endif

        for (int k = 0; k < WORDS; k++) cycle(1'b0, 32'h0, 1'b1, 4'hF, k * 4, $urandom);

`ifndef TCM_CLEAR_EN
        cycle(1'b1, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
        idle_inputs();
        reset = 1'b1;
        step();
        check("rst2_imem", imem_dout, 32'h0);
        check("rst2_dmem", dmem_dout, 32'h0);
        reset = 1'b0;
        exp_i = '0;
        exp_d = '0;
        for (int k = 0; k < WORDS; k++) cycle(1'b1, k * 4, 1'b1, 4'h0, k * 4, 32'h0);
`endif

        // Byte-lane merge
        cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h08, 32'hDEAD_BEEF);
        cycle(1'b0, 32'h0, 1'b1, 4'b0010, 32'h08, 32'h0000_5500);
        cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h08, 32'h0);
        check("merge_word", dmem_dout, 32'hDEAD_55EF);

        // Same-word imem read during dmem write returns the old word
        cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h10, 32'hAAAA_AAAA);
        cycle(1'b1, 32'h10, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
        check("collide_old", imem_dout, 32'hAAAA_AAAA);
        cycle(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
        check("collide_new", imem_dout, 32'h1234_5678);

        // Hold with enables low while other inputs churn
        cycle(1'b1, 32'h0C, 1'b1, 4'h0, 32'h04, 32'h0);
        repeat (3) cycle(1'b0, $urandom, 1'b0, 4'($urandom), $urandom, $urandom);

        // Out-of-range data write, then confirm word 0 untouched
        cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF);
        check("oor_err", {31'b0, dmem_err}, 32'h1);
        check("oor_dout", dmem_dout, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 4'h0, 32'h03, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ia, da;
            ia = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 63);
            da = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 63);
            cycle(1'($urandom), ia, 1'($urandom), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                  da, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
